// File: rtl/ut_core_arbiter.sv
// ut_core_arbiter: round-robin share of one timestamp-to-BCD core among NREQ requesters.
// Collects the serial digit burst into one packed word and returns it tagged with the requester id.
module ut_core_arbiter #(
   parameter int NREQ     = 4,
   parameter int ID_W     = 2,
   parameter int TIME_W   = 31,
   parameter int DIGITS   = 14,
   parameter int MAX_WAIT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*TIME_W-1:0]   req_time,
   output logic [NREQ-1:0]          req_ready,
   output logic                     core_in_valid,
   output logic [TIME_W-1:0]        core_in_time,
   input  logic                     core_out_valid,
   input  logic [3:0]               core_out_display,
   input  logic [2:0]               core_out_day,
   output logic                     resp_valid,
   output logic [ID_W-1:0]          resp_id,
   output logic [4*DIGITS-1:0]      resp_bcd,
   output logic [2:0]               resp_day,
   output logic                     resp_err
);
   localparam int TW = $clog2(MAX_WAIT + 1);
   localparam int CW = $clog2(DIGITS + 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COLLECT, RESP} state_t;
   state_t state;
   logic [ID_W-1:0] rr_ptr, id, gid;
   logic [ID_W:0] j;
   logic [TW-1:0] timer;
   logic [CW-1:0] cnt;
   logic [4*DIGITS-5:0] sr;
   logic [2:0] day;
   // scan from the highest offset down so the nearest valid requester after rr_ptr wins
   always_comb begin
      gid = '0;
      j = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = {1'b0, rr_ptr} + (ID_W+1)'(i);
         j = (j >= (ID_W+1)'(NREQ)) ? j - (ID_W+1)'(NREQ) : j;
         gid = req_valid[j[ID_W-1:0]] ? j[ID_W-1:0] : gid;
      end
   end
   assign req_ready = (rst_n && state == IDLE && |req_valid) ? NREQ'(1) << gid : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rr_ptr <= '0;
         id <= '0;
         timer <= '0;
         cnt <= '0;
         sr <= '0;
         day <= '0;
         core_in_valid <= 1'b0;
         core_in_time <= '0;
         resp_valid <= 1'b0;
         resp_id <= '0;
         resp_bcd <= '0;
         resp_day <= '0;
         resp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               id <= gid;
               core_in_valid <= 1'b1;
               core_in_time <= req_time[gid*TIME_W +: TIME_W];
               state <= ISSUE;
            end
            ISSUE: begin
               core_in_valid <= 1'b0;
               core_in_time <= '0;
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= (timer == TW'(MAX_WAIT)) ? timer : timer + 1'b1;
               if (core_out_valid) begin
                  sr <= (4*DIGITS-4)'(core_out_display);
                  day <= core_out_day;
                  cnt <= CW'(1);
                  state <= COLLECT;
               end else if (timer == TW'(MAX_WAIT - 1)) begin
                  resp_valid <= 1'b1;
                  resp_id <= id;
                  resp_err <= 1'b1;
                  state <= RESP;
               end
            end
            COLLECT: begin
               if (!core_out_valid) begin
                  resp_valid <= 1'b1;
                  resp_id <= id;
                  resp_err <= 1'b1;
                  state <= RESP;
               end else if (cnt == CW'(DIGITS - 1)) begin
                  resp_valid <= 1'b1;
                  resp_id <= id;
                  resp_bcd <= {sr, core_out_display};
                  resp_day <= day;
                  state <= RESP;
               end else begin
                  sr <= {sr[4*DIGITS-9:0], core_out_display};
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_id <= '0;
               resp_bcd <= '0;
               resp_day <= '0;
               resp_err <= 1'b0;
               rr_ptr <= (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
